// File: rtl/if_fetch_stage_pkg.sv
// rtl/if_fetch_stage_pkg.sv - shared constants and FSM encoding for the fetch stage
package if_fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// rtl/if_fetch_stage_if_id_reg.sv - IF/ID pipeline register with flush > stall > load > bubble
//
// Ports:
//   clk, resetn            clock, async active-low reset
//   flush, stall, load     update controls (priority in that order)
//   load_instr/pc/adel     slot contents written on load
//   instr, pc, valid, adel registered slot presented to decode
module if_id_reg #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        stall,
    input  logic        load,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    input  logic        load_adel,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        valid,
    output logic        adel
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic        adel_q, adel_d;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        adel_d  = adel_q;
        if (flush) begin
            // pc is kept so a later exception report still has a meaningful PC
            instr_d = NOP_WORD;
            valid_d = 1'b0;
            adel_d  = 1'b0;
        end else if (stall) begin
            // hold everything
        end else if (load) begin
            instr_d = load_instr;
            pc_d    = load_pc;
            valid_d = 1'b1;
            adel_d  = load_adel;
        end else begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
            adel_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            instr_q <= NOP_WORD;
            pc_q    <= 32'h0;
            valid_q <= 1'b0;
            adel_q  <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            adel_q  <= adel_d;
        end
    end

    assign instr = instr_q;
    assign pc    = pc_q;
    assign valid = valid_q;
    assign adel  = adel_q;

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch FSM, fetch PC, skid buffer and IF/ID register
//
// Ports:
//   clk, resetn                          clock, async active-low reset
//   inst_req/addr/addr_ok/rdata/data_ok  SRAM-like instruction port, one outstanding request
//   stall_d, flush_d                     decode back-pressure and IF/ID flush
//   redirect_valid, redirect_pc          taken branch/jump target
//   instr_d, pc_d, valid_d, adel_d       IF/ID slot presented to decode
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic [31:0] inst_rdata,
    input  logic        inst_data_ok,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic        valid_d,
    output logic        adel_d
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_f_q, pc_f_d;
    logic         cancel_q, cancel_d;
    // set after an address-error slot: IDLE then waits for a redirect instead of refetching
    logic         park_q, park_d;
    logic [31:0]  skid_instr_q, skid_instr_d;
    logic [31:0]  skid_pc_q, skid_pc_d;

    logic         misaligned;
    logic         ifid_load;
    logic [31:0]  ifid_instr;
    logic [31:0]  ifid_pc;
    logic         ifid_adel;

    assign misaligned = (pc_f_q[1:0] != 2'b00);

    always_comb begin
        state_d      = state_q;
        pc_f_d       = pc_f_q;
        cancel_d     = cancel_q;
        park_d       = park_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        ifid_load    = 1'b0;
        ifid_instr   = inst_rdata;
        ifid_pc      = pc_f_q;
        ifid_adel    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // any data_ok seen here belongs to a transaction killed by reset
                if (redirect_valid) begin
                    pc_f_d  = redirect_pc;
                    park_d  = 1'b0;
                    state_d = S_REQ;
                end else if (!park_q) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (misaligned) begin
                    if (redirect_valid) begin
                        pc_f_d = redirect_pc;
                    end else if (!stall_d) begin
                        ifid_load  = 1'b1;
                        ifid_instr = NOP_WORD;
                        ifid_adel  = 1'b1;
                        park_d     = 1'b1;
                        state_d    = S_IDLE;
                    end
                end else if (inst_addr_ok) begin
                    state_d = S_WAIT;
                    if (redirect_valid) begin
                        // accepted request now fetches the wrong path; drop its data
                        cancel_d = 1'b1;
                        pc_f_d   = redirect_pc;
                    end
                end else if (redirect_valid) begin
                    pc_f_d = redirect_pc;
                end
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    state_d = S_REQ;
                    if (cancel_q) begin
                        cancel_d = 1'b0;
                        if (redirect_valid) begin
                            pc_f_d = redirect_pc;
                        end
                    end else if (redirect_valid) begin
                        pc_f_d = redirect_pc;
                    end else begin
                        pc_f_d = pc_f_q + 32'd4;
                        if (stall_d) begin
                            skid_instr_d = inst_rdata;
                            skid_pc_d    = pc_f_q;
                            state_d      = S_HOLD;
                        end else begin
                            ifid_load = 1'b1;
                        end
                    end
                end else if (redirect_valid) begin
                    cancel_d = 1'b1;
                    pc_f_d   = redirect_pc;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_f_d  = redirect_pc;
                    state_d = S_REQ;
                end else if (!stall_d) begin
                    ifid_load  = 1'b1;
                    ifid_instr = skid_instr_q;
                    ifid_pc    = skid_pc_q;
                    state_d    = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            pc_f_q       <= RESET_PC;
            cancel_q     <= 1'b0;
            park_q       <= 1'b0;
            skid_instr_q <= NOP_WORD;
            skid_pc_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_f_q       <= pc_f_d;
            cancel_q     <= cancel_d;
            park_q       <= park_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign inst_req  = (state_q == S_REQ) && !misaligned;
    assign inst_addr = pc_f_q;

    if_id_reg #(
        .NOP_WORD(NOP_WORD)
    ) u_if_id_reg (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush_d),
        .stall     (stall_d),
        .load      (ifid_load),
        .load_instr(ifid_instr),
        .load_pc   (ifid_pc),
        .load_adel (ifid_adel),
        .instr     (instr_d),
        .pc        (pc_d),
        .valid     (valid_d),
        .adel      (adel_d)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed self-checking bench for if_fetch_stage
module tb_if_fetch_stage;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;
    logic        stall_d;
    logic        flush_d;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic        valid_d;
    logic        adel_d;

    int vectors;
    int miscompares;

    if_fetch_stage dut (
        .clk           (clk),
        .resetn        (resetn),
        .inst_req      (inst_req),
        .inst_addr     (inst_addr),
        .inst_addr_ok  (inst_addr_ok),
        .inst_rdata    (inst_rdata),
        .inst_data_ok  (inst_data_ok),
        .stall_d       (stall_d),
        .flush_d       (flush_d),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_d       (instr_d),
        .pc_d          (pc_d),
        .valid_d       (valid_d),
        .adel_d        (adel_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_addr_ok   = 1'b0;
        inst_data_ok   = 1'b0;
        inst_rdata     = 32'h0;
        stall_d        = 1'b0;
        flush_d        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
    endtask

    task automatic test_reset();
        logic [32:0] exp_req;
        logic [65:0] exp_slot;
        resetn = 1'b0;
        idle_inputs();
        tick();
        tick();
        exp_req  = {1'b0, 32'hBFC0_0000};
        exp_slot = {1'b0, 1'b0, 32'h0, 32'h0};
        vectors++;
        if ({inst_req, inst_addr} !== exp_req) begin
            miscompares++;
            $display("FAIL reset_req got %h exp %h", {inst_req, inst_addr}, exp_req);
        end
        vectors++;
        if ({valid_d, adel_d, pc_d, instr_d} !== exp_slot) begin
            miscompares++;
            $display("FAIL reset_slot got %h exp %h", {valid_d, adel_d, pc_d, instr_d}, exp_slot);
        end
        resetn = 1'b1;
        tick();
        exp_req = {1'b1, 32'hBFC0_0000};
        vectors++;
        if ({inst_req, inst_addr} !== exp_req) begin
            miscompares++;
            $display("FAIL first_req got %h exp %h", {inst_req, inst_addr}, exp_req);
        end
    endtask

    task automatic test_sequential();
        logic [32:0] exp_req;
        logic [65:0] exp_slot;
        for (int i = 0; i < 4; i++) begin
            exp_req = {1'b1, 32'hBFC0_0000 + 32'(4 * i)};
            vectors++;
            if ({inst_req, inst_addr} !== exp_req) begin
                miscompares++;
                $display("FAIL seq_req%0d got %h exp %h", i, {inst_req, inst_addr}, exp_req);
            end
            inst_addr_ok = 1'b1;
            tick();
            inst_addr_ok = 1'b0;
            vectors++;
            if ({inst_req, valid_d} !== 2'b00) begin
                miscompares++;
                $display("FAIL seq_wait%0d got req/valid %b exp 00", i, {inst_req, valid_d});
            end
            inst_data_ok = 1'b1;
            inst_rdata   = 32'h1000 + 32'(i);
            tick();
            inst_data_ok = 1'b0;
            exp_slot = {1'b1, 1'b0, 32'hBFC0_0000 + 32'(4 * i), 32'h1000 + 32'(i)};
            vectors++;
            if ({valid_d, adel_d, pc_d, instr_d} !== exp_slot) begin
                miscompares++;
                $display("FAIL seq_slot%0d got %h exp %h", i, {valid_d, adel_d, pc_d, instr_d}, exp_slot);
            end
        end
    endtask

    task automatic test_stall_skid();
        logic [65:0] exp_slot;
        // pc_f = BFC00010, in REQ
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        stall_d      = 1'b1;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h2402_0001;
        tick();
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({inst_req, valid_d} !== 2'b00) begin
                miscompares++;
                $display("FAIL hold_%0d got req/valid %b exp 00", i, {inst_req, valid_d});
            end
            tick();
        end
        stall_d = 1'b0;
        vectors++;
        if ({inst_req, valid_d} !== 2'b00) begin
            miscompares++;
            $display("FAIL hold_last got req/valid %b exp 00", {inst_req, valid_d});
        end
        tick();
        exp_slot = {1'b1, 1'b0, 32'hBFC0_0010, 32'h2402_0001};
        vectors++;
        if ({valid_d, adel_d, pc_d, instr_d} !== exp_slot) begin
            miscompares++;
            $display("FAIL skid_slot got %h exp %h", {valid_d, adel_d, pc_d, instr_d}, exp_slot);
        end
        vectors++;
        if ({inst_req, inst_addr} !== {1'b1, 32'hBFC0_0014}) begin
            miscompares++;
            $display("FAIL skid_next_req got %h exp %h", {inst_req, inst_addr}, {1'b1, 32'hBFC0_0014});
        end
    endtask

    task automatic test_redirect_wait();
        logic [65:0] exp_slot;
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok   = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hBFC0_0100;
        tick();
        redirect_valid = 1'b0;
        vectors++;
        if ({inst_req, inst_addr} !== {1'b0, 32'hBFC0_0100}) begin
            miscompares++;
            $display("FAIL redir_wait_addr got %h exp %h", {inst_req, inst_addr}, {1'b0, 32'hBFC0_0100});
        end
        inst_data_ok = 1'b1;
        inst_rdata   = 32'hDEAD_BEEF;
        tick();
        inst_data_ok = 1'b0;
        vectors++;
        if (valid_d !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_drop got valid %b exp 0", valid_d);
        end
        vectors++;
        if ({inst_req, inst_addr} !== {1'b1, 32'hBFC0_0100}) begin
            miscompares++;
            $display("FAIL redir_req got %h exp %h", {inst_req, inst_addr}, {1'b1, 32'hBFC0_0100});
        end
        // addr_ok delayed two cycles: request must stay up
        tick();
        tick();
        vectors++;
        if ({inst_req, inst_addr} !== {1'b1, 32'hBFC0_0100}) begin
            miscompares++;
            $display("FAIL delayed_req got %h exp %h", {inst_req, inst_addr}, {1'b1, 32'hBFC0_0100});
        end
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h8C43_0000;
        tick();
        inst_data_ok = 1'b0;
        exp_slot = {1'b1, 1'b0, 32'hBFC0_0100, 32'h8C43_0000};
        vectors++;
        if ({valid_d, adel_d, pc_d, instr_d} !== exp_slot) begin
            miscompares++;
            $display("FAIL redir_target_slot got %h exp %h", {valid_d, adel_d, pc_d, instr_d}, exp_slot);
        end
    endtask

    task automatic test_redirect_with_data();
        logic [65:0] exp_slot;
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok   = 1'b0;
        inst_data_ok   = 1'b1;
        inst_rdata     = 32'h1111_1111;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hBFC0_0200;
        tick();
        inst_data_ok   = 1'b0;
        redirect_valid = 1'b0;
        vectors++;
        if ({valid_d, inst_req, inst_addr} !== {1'b0, 1'b1, 32'hBFC0_0200}) begin
            miscompares++;
            $display("FAIL same_cycle got %h exp %h", {valid_d, inst_req, inst_addr}, {1'b0, 1'b1, 32'hBFC0_0200});
        end
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h2222_2222;
        tick();
        inst_data_ok = 1'b0;
        exp_slot = {1'b1, 1'b0, 32'hBFC0_0200, 32'h2222_2222};
        vectors++;
        if ({valid_d, adel_d, pc_d, instr_d} !== exp_slot) begin
            miscompares++;
            $display("FAIL no_cancel_left got %h exp %h", {valid_d, adel_d, pc_d, instr_d}, exp_slot);
        end
    endtask

    task automatic test_flush_stall();
        logic [65:0] exp_slot;
        stall_d = 1'b1;
        tick();
        exp_slot = {1'b1, 1'b0, 32'hBFC0_0200, 32'h2222_2222};
        vectors++;
        if ({valid_d, adel_d, pc_d, instr_d} !== exp_slot) begin
            miscompares++;
            $display("FAIL stall_hold got %h exp %h", {valid_d, adel_d, pc_d, instr_d}, exp_slot);
        end
        flush_d = 1'b1;
        tick();
        stall_d = 1'b0;
        flush_d = 1'b0;
        exp_slot = {1'b0, 1'b0, 32'hBFC0_0200, 32'h0};
        vectors++;
        if ({valid_d, adel_d, pc_d, instr_d} !== exp_slot) begin
            miscompares++;
            $display("FAIL flush_stall got %h exp %h", {valid_d, adel_d, pc_d, instr_d}, exp_slot);
        end
        vectors++;
        if ({inst_req, inst_addr} !== {1'b1, 32'hBFC0_0204}) begin
            miscompares++;
            $display("FAIL flush_fsm got %h exp %h", {inst_req, inst_addr}, {1'b1, 32'hBFC0_0204});
        end
    endtask

    task automatic test_adel();
        logic [65:0] exp_slot;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hBFC0_0102;
        tick();
        redirect_valid = 1'b0;
        vectors++;
        if ({inst_req, inst_addr} !== {1'b0, 32'hBFC0_0102}) begin
            miscompares++;
            $display("FAIL adel_noreq got %h exp %h", {inst_req, inst_addr}, {1'b0, 32'hBFC0_0102});
        end
        tick();
        exp_slot = {1'b1, 1'b1, 32'hBFC0_0102, 32'h0};
        vectors++;
        if ({valid_d, adel_d, pc_d, instr_d} !== exp_slot) begin
            miscompares++;
            $display("FAIL adel_slot got %h exp %h", {valid_d, adel_d, pc_d, instr_d}, exp_slot);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({inst_req, valid_d, adel_d} !== 3'b000) begin
                miscompares++;
                $display("FAIL adel_park%0d got req/valid/adel %b exp 000", i, {inst_req, valid_d, adel_d});
            end
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'hBFC0_0300;
        tick();
        redirect_valid = 1'b0;
        vectors++;
        if ({inst_req, inst_addr} !== {1'b1, 32'hBFC0_0300}) begin
            miscompares++;
            $display("FAIL adel_leave got %h exp %h", {inst_req, inst_addr}, {1'b1, 32'hBFC0_0300});
        end
    endtask

    task automatic test_reset_mid();
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        resetn = 1'b0;
        #1;
        vectors++;
        if ({inst_req, inst_addr, valid_d, pc_d} !== {1'b0, 32'hBFC0_0000, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL async_reset got %h exp %h", {inst_req, inst_addr, valid_d, pc_d},
                     {1'b0, 32'hBFC0_0000, 1'b0, 32'h0});
        end
        tick();
        resetn       = 1'b1;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h3333_3333;
        tick();
        inst_data_ok = 1'b0;
        vectors++;
        if ({valid_d, inst_req, inst_addr} !== {1'b0, 1'b1, 32'hBFC0_0000}) begin
            miscompares++;
            $display("FAIL stale_data got %h exp %h", {valid_d, inst_req, inst_addr}, {1'b0, 1'b1, 32'hBFC0_0000});
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_sequential();
        test_stall_skid();
        test_redirect_wait();
        test_redirect_with_data();
        test_flush_stall();
        test_adel();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
